i2c_bit_rx: RTL and testbench
=============================

// Module: i2c_bit_rx
// PURPOSE
//  Bit-level I2C bus decoder; the receive-side counterpart of the 4-tap bit executor.
//  Samples raw SCL/SDA, detects START, STOP and data bits, and emits each as a 3-bit
//  event code (same codes as the TX command set) through a small valid/ready FIFO.
//  Sits under the future byte-level slave/monitor FSM.
// PARAMETERS
//  FIFO_DEPTH  4  event FIFO entries; power of 2, >=2
//  FILTER_LEN  3  glitch-filter stability count in clocks (used only with I2C_BIT_RX_FILTER_EN)
// PORTS
//  clock      in   1  system clock
//  rst_n      in   1  async active-low reset
//  scl_i      in   1  raw SCL pin level (asynchronous)
//  sda_i      in   1  raw SDA pin level (asynchronous)
//  evt_vld    out  1  FIFO head valid
//  evt        out  3  event code: 1=START 2=BIT1 3=BIT0 4=STOP
//  evt_ready  in   1  consumer accepts head when evt_vld&evt_ready
//  bus_busy   out  1  high from START until STOP
//  overflow   out  1  sticky: event dropped because FIFO full
//  ovf_clr    in   1  one-cycle pulse clears overflow
// BEHAVIOUR
//  - Clock: one clock; reset asynchronous, active-low. Reset: evt_vld=0, evt=0, bus_busy=0,
//    overflow=0, sync/filter/prev regs=1 (bus idle), FIFO empty, FSM=IDLE.
//  - 2-FF synchroniser on each line -> scl_s/sda_s. Filtered lines scl_f/sda_f; prev copies scl_q/sda_q.
//  - start_det = scl_f&scl_q&sda_q&~sda_f; stop_det = scl_f&scl_q&~sda_q&sda_f;
//    scl_rise = scl_f&~scl_q; scl_fall = ~scl_f&scl_q. SCL edge in same cycle as SDA edge:
//    SCL edge wins, no START/STOP.
//  - FSM states IDLE, HOLD, LOW, HIGH; start_det in any state -> push START, go HOLD (repeated START ok).
//    IDLE: all else ignored (incl. stop_det).
//    HOLD: stop_det -> push STOP, IDLE; scl_fall -> LOW.
//    LOW : scl_rise -> latch bit=sda_f, HIGH.
//    HIGH: scl_fall -> push BIT1 if bit else BIT0, LOW; stop_det -> push STOP, IDLE (no bit pushed).
//    LOW/HIGH: stop_det in LOW impossible (scl low); no other transitions.
//  - bus_busy set with START push, cleared with STOP push.
//  - FIFO: push when full and no pop same cycle -> event dropped, overflow<=1. Push+pop same
//    cycle when full -> both succeed. Pop on empty ignored. ovf_clr and new overflow same cycle -> overflow=1.
//  - Latency (macro off, FIFO empty): evt_vld high 4 clocks after the first clock edge that samples
//    the new pin level (2 sync + 1 detect/FSM + 1 FIFO write). Macro on: +FILTER_LEN clocks.
//  - Throughput: 1 event/clock into FIFO; evt stable while evt_vld&~evt_ready.
//  - Reset mid-transfer: everything returns to reset values; bits ignored until next START.
// CONFIGURATION
//  I2C_BIT_RX_FILTER_EN defined: per line a counter; scl_f/sda_f change only after synchronised
//    level differs from filtered level for FILTER_LEN consecutive clocks; counter clears on any
//    match. Pulses shorter than FILTER_LEN clocks produce no event.
//  Not defined: scl_f=scl_s, sda_f=sda_s; FILTER_LEN unused.
// STRUCTURE
//  i2c_pkg: CMD_START/CMD_1/CMD_0/CMD_STOP (3-bit localparams, values 1..4), rx FSM enum.
//  Sub-module i2c_evt_fifo: synchronous FIFO, DEPTH and WIDTH=3 parameters, push/pop/full/empty.
//  Top holds sync, filter, edge detect, FSM, overflow/busy logic.
// TESTING
//  1. SDA falls while SCL high, then SCL falls -> one evt=1, bus_busy=1, latency 4 clocks (macro off).
//  2. START then 8 bits 0xA5 (quarter-period 10 clocks) -> evt 1,2,3,2,3,3,2,3,2 in order.
//  3. Bit then SDA rises during SCL high -> evt=4, bus_busy=0, no bit event for that SCL high.
//  4. evt_ready=0, START+5 bits with FIFO_DEPTH=4 -> 4 events held, overflow=1; ovf_clr -> 0.
//  5. Macro on, FILTER_LEN=3: 2-clock SDA low glitch with SCL high -> no event; 3-clock -> START.
//  6. rst_n low mid-byte, release, 3 SCL pulses -> no events until next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - I2C bit-level event codes and receive FSM state type
`timescale 1ns/1ps

package i2c_pkg;

   localparam logic [2:0] CMD_NONE  = 3'd0;
   localparam logic [2:0] CMD_START = 3'd1;
   localparam logic [2:0] CMD_1     = 3'd2;
   localparam logic [2:0] CMD_0     = 3'd3;
   localparam logic [2:0] CMD_STOP  = 3'd4;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_HOLD,
      RX_LOW,
      RX_HIGH
   } rx_state_t;

   function automatic logic [2:0] bit_code(input logic b);
      return b ? CMD_1 : CMD_0;
   endfunction

endpackage

// File: rtl/i2c_evt_fifo.sv
// rtl/i2c_evt_fifo.sv - small synchronous event FIFO; full-with-pop accepts the push
`timescale 1ns/1ps

module i2c_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + (AW+1)'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/i2c_bit_rx.sv
// rtl/i2c_bit_rx.sv - I2C bit-level receive decoder (START/STOP/bit events into a FIFO)
// Optional glitch filter on SCL/SDA enabled by I2C_BIT_RX_FILTER_EN.
`timescale 1ns/1ps

module i2c_bit_rx
   import i2c_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int FILTER_LEN = 3
) (
   input  logic       clock,
   input  logic       rst_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       evt_vld,
   output logic [2:0] evt,
   input  logic       evt_ready,
   output logic       bus_busy,
   output logic       overflow,
   input  logic       ovf_clr
);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FILTER_LEN < 1) begin : g_param_check
      $error("i2c_bit_rx: FIFO_DEPTH must be a power of 2 >= 2 and FILTER_LEN >= 1");
   end

   logic [1:0] scl_sync;
   logic [1:0] sda_sync;
   logic       scl_s;
   logic       sda_s;
   logic       scl_f;
   logic       sda_f;
   logic       scl_q;
   logic       sda_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync <= 2'b11;
         sda_sync <= 2'b11;
      end else begin
         scl_sync <= {scl_sync[0], scl_i};
         sda_sync <= {sda_sync[0], sda_i};
      end
   end

   assign scl_s = scl_sync[1];
   assign sda_s = sda_sync[1];

`ifdef I2C_BIT_RX_FILTER_EN
   localparam int CW = $clog2(FILTER_LEN + 1);

   logic [1:0]    lvl_s;
   logic [1:0]    lvl_f;
   logic [CW-1:0] cnt [2];

   assign lvl_s = {scl_s, sda_s};
   assign scl_f = lvl_f[1];
   assign sda_f = lvl_f[0];

   // Filtered level follows only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         lvl_f  <= 2'b11;
         cnt[0] <= '0;
         cnt[1] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (lvl_s[i] == lvl_f[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
               lvl_f[i] <= lvl_s[i];
               cnt[i]   <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end
`else
   assign scl_f = scl_s;
   assign sda_f = sda_s;
`endif

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         scl_q <= 1'b1;
         sda_q <= 1'b1;
      end else begin
         scl_q <= scl_f;
         sda_q <= sda_f;
      end
   end

   logic start_det;
   logic stop_det;
   logic scl_rise;
   logic scl_fall;

   // Both conditions need SCL steady high, so an SCL edge always takes precedence.
   assign start_det = scl_f & scl_q & sda_q & ~sda_f;
   assign stop_det  = scl_f & scl_q & ~sda_q & sda_f;
   assign scl_rise  = scl_f & ~scl_q;
   assign scl_fall  = ~scl_f & scl_q;

   rx_state_t  state;
   logic       push;
   logic [2:0] push_code;
   logic       bit_val;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RX_IDLE;
         push      <= 1'b0;
         push_code <= CMD_NONE;
         bit_val   <= 1'b0;
         bus_busy  <= 1'b0;
      end else begin
         push <= 1'b0;
         if (start_det) begin
            push      <= 1'b1;
            push_code <= CMD_START;
            bus_busy  <= 1'b1;
            state     <= RX_HOLD;
         end else begin
            case (state)
               RX_IDLE: ;
               RX_HOLD: begin
                  if (stop_det) begin
                     push      <= 1'b1;
                     push_code <= CMD_STOP;
                     bus_busy  <= 1'b0;
                     state     <= RX_IDLE;
                  end else if (scl_fall) begin
                     state <= RX_LOW;
                  end
               end
               RX_LOW: begin
                  if (scl_rise) begin
                     bit_val <= sda_f;
                     state   <= RX_HIGH;
                  end
               end
               RX_HIGH: begin
                  if (scl_fall) begin
                     push      <= 1'b1;
                     push_code <= bit_code(bit_val);
                     state     <= RX_LOW;
                  end else if (stop_det) begin
                     push      <= 1'b1;
                     push_code <= CMD_STOP;
                     bus_busy  <= 1'b0;
                     state     <= RX_IDLE;
                  end
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

   logic       fifo_full;
   logic       fifo_empty;
   logic [2:0] fifo_rdata;

   i2c_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (3)
   ) u_fifo (
      .clock (clock),
      .rst_n (rst_n),
      .push  (push),
      .wdata (push_code),
      .pop   (evt_ready),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt_vld = ~fifo_empty;
   assign evt     = fifo_empty ? CMD_NONE : fifo_rdata;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (push & fifo_full & ~evt_ready) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_i2c_bit_rx.sv
// tb/tb_i2c_bit_rx.sv - scoreboard bench for i2c_bit_rx (I2C_BIT_RX_FILTER_EN selects filter cases)
`timescale 1ns/1ps

module tb_i2c_bit_rx;
   import i2c_pkg::*;

   localparam int Q = 10;
`ifdef I2C_BIT_RX_FILTER_EN
   localparam int LAT = 4 + 3;
`else
   localparam int LAT = 4;
`endif

   logic       clock = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_i = 1'b1;
   logic       sda_i = 1'b1;
   logic       evt_ready = 1'b1;
   logic       ovf_clr = 1'b0;
   logic       evt_vld;
   logic [2:0] evt;
   logic       bus_busy;
   logic       overflow;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q [$];

   i2c_bit_rx #(.FIFO_DEPTH(4), .FILTER_LEN(3)) dut (
      .clock     (clock),
      .rst_n     (rst_n),
      .scl_i     (scl_i),
      .sda_i     (sda_i),
      .evt_vld   (evt_vld),
      .evt       (evt),
      .evt_ready (evt_ready),
      .bus_busy  (bus_busy),
      .overflow  (overflow),
      .ovf_clr   (ovf_clr)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   always @(negedge clock) begin
      if (rst_n && evt_vld && evt_ready) begin
         if (exp_q.size() == 0) chk("evt_unexpected", evt, CMD_NONE);
         else chk("evt", evt, exp_q.pop_front());
      end
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic start_cond(input bit e);
      if (e) exp_q.push_back(CMD_START);
      sda_i = 1'b0; wait_clk(Q);
      scl_i = 1'b0; wait_clk(Q);
   endtask

   task automatic send_bit(input bit b, input bit e);
      if (e) exp_q.push_back(b ? CMD_1 : CMD_0);
      sda_i = b;    wait_clk(Q);
      scl_i = 1'b1; wait_clk(2*Q);
      scl_i = 1'b0; wait_clk(Q);
   endtask

   task automatic stop_cond(input bit e);
      if (e) exp_q.push_back(CMD_STOP);
      sda_i = 1'b0; wait_clk(Q);
      scl_i = 1'b1; wait_clk(Q);
      sda_i = 1'b1; wait_clk(Q);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) wait_clk(1);
      chk(tag, exp_q.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      logic [7:0] byte_a5;
      byte_a5 = 8'hA5;

      wait_clk(3);
      chk("rst_evt_vld", evt_vld, 0);
      chk("rst_evt", evt, 0);
      chk("rst_bus_busy", bus_busy, 0);
      chk("rst_overflow", overflow, 0);
      rst_n = 1'b1;
      wait_clk(5);

      // START latency, then 0xA5 and STOP
      exp_q.push_back(CMD_START);
      sda_i = 1'b0;
      for (int n = 1; n <= LAT; n++) begin
         @(posedge clock); #1;
         chk(n < LAT ? "lat_early" : "lat_valid", evt_vld, (n == LAT) ? 1 : 0);
      end
      chk("busy_after_start", bus_busy, 1);
      @(negedge clock);
      wait_clk(Q);
      scl_i = 1'b0; wait_clk(Q);
      for (int i = 7; i >= 0; i--) send_bit(byte_a5[i], 1'b1);
      stop_cond(1'b1);
      drain("drain_a5");
      chk("busy_after_stop", bus_busy, 0);
      chk("ovf_a5", overflow, 0);

      // FIFO overflow with consumer stalled
      evt_ready = 1'b0;
      start_cond(1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      wait_clk(5);
      chk("full_vld", evt_vld, 1);
      chk("hold_head", evt, CMD_START);
      chk("ovf_set", overflow, 1);
      ovf_clr = 1'b1; wait_clk(1);
      ovf_clr = 1'b0; wait_clk(1);
      chk("ovf_clr", overflow, 0);
      evt_ready = 1'b1;
      drain("drain_ovf");
      stop_cond(1'b1);
      drain("drain_ovf_stop");
      chk("busy_ovf_stop", bus_busy, 0);

      // reset mid-byte, stray SCL pulses must be ignored
      start_cond(1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      drain("drain_pre_rst");
      sda_i = 1'b1; wait_clk(Q);
      scl_i = 1'b1; wait_clk(Q);
      rst_n = 1'b0; wait_clk(3);
      chk("midrst_vld", evt_vld, 0);
      chk("midrst_busy", bus_busy, 0);
      rst_n = 1'b1; wait_clk(Q);
      scl_i = 1'b0; wait_clk(Q);
      for (int i = 0; i < 3; i++) begin
         sda_i = i[0]; wait_clk(Q);
         scl_i = 1'b1; wait_clk(2*Q);
         scl_i = 1'b0; wait_clk(Q);
      end
      wait_clk(10);
      chk("post_rst_vld", evt_vld, 0);
      chk("post_rst_busy", bus_busy, 0);
      sda_i = 1'b1; wait_clk(Q);
      scl_i = 1'b1; wait_clk(Q);
      start_cond(1'b1);
      send_bit(1'b0, 1'b1);
      stop_cond(1'b1);
      drain("drain_recover");
      chk("busy_recover", bus_busy, 0);

`ifdef I2C_BIT_RX_FILTER_EN
      // glitch shorter than the filter is dropped, one of exact length is a START
      wait_clk(Q);
      sda_i = 1'b0; wait_clk(2);
      sda_i = 1'b1; wait_clk(20);
      chk("glitch_vld", evt_vld, 0);
      chk("glitch_busy", bus_busy, 0);
      exp_q.push_back(CMD_START);
      sda_i = 1'b0; wait_clk(3);
      wait_clk(Q);
      chk("filt_busy", bus_busy, 1);
      scl_i = 1'b0; wait_clk(Q);
      stop_cond(1'b1);
      drain("drain_filter");
`endif

      wait_clk(10);
      chk("final_q", exp_q.size(), 0);
      chk("final_ovf", overflow, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
